pattern_gen: RTL and testbench

- Serial bit-stream transmitter. It is the source end of the d/valid serial interface consumed by the team's pattern detectors.
- Loads a pattern word plus a length, repeat count and inter-repetition gap.
- Shifts the pattern out MSB-first, one bit per valid cycle, with a hold input for stalls.
- Used in bench and datapath to drive detector inputs d_i/valid_i from d_o/valid_o.

---
 rtl/pattern_gen.sv | 137 +++++++++++++
 tb/tb_pattern_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Serial bit-stream source: shifts a latched pattern out MSB-first on d_o/valid_o,
// repeated rep times with gap idle cycles between repetitions and hold_i stalls.
module pattern_gen #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       pat_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic [REP_W-1:0]       rep_i,
  input  logic [GAP_W-1:0]       gap_i,
  input  logic                   hold_i,
  output logic                   d_o,
  output logic                   valid_o,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [LEN_W+REP_W-1:0] sent_cnt,
  output logic [1:0]             state_dbg
);

  // Stream protocol: d_o is meaningful only in cycles where valid_o=1; there is
  // no backpressure, the consumer must accept every valid bit as it appears.

  localparam int CNT_W = LEN_W + REP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [REP_W-1:0]   rep_r;
  logic [GAP_W-1:0]   gap_r;
  logic [LEN_W-1:0]   bit_idx;
  logic [REP_W-1:0]   rep_idx;
  logic [GAP_W-1:0]   gap_cnt;

  logic               legal;
  logic [LEN_W-1:0]   cur_pos;
  logic               cur_bit;

  always_comb begin
    legal   = (len_i != '0) && (len_i <= LEN_W'(WIDTH)) && (rep_i != '0);
    cur_pos = len_r - LEN_W'(1) - bit_idx;
    cur_bit = |(pat_r & (WIDTH'(1) << cur_pos));
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      d_o      <= 1'b0;
      valid_o  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sent_cnt <= '0;
      pat_r    <= '0;
      len_r    <= '0;
      rep_r    <= '0;
      gap_r    <= '0;
      bit_idx  <= '0;
      rep_idx  <= '0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            if (legal) begin
              pat_r    <= pat_i;
              len_r    <= len_i;
              rep_r    <= rep_i;
              gap_r    <= gap_i;
              sent_cnt <= '0;
              bit_idx  <= '0;
              rep_idx  <= '0;
              gap_cnt  <= '0;
              busy     <= 1'b1;
              state    <= SEND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEND: begin
          // rep_idx reaching rep means the final bit went out on the previous edge
          if (rep_idx == rep_r) begin
            valid_o <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (hold_i) begin
            valid_o <= 1'b0;
          end else begin
            d_o      <= cur_bit;
            valid_o  <= 1'b1;
            sent_cnt <= sent_cnt + CNT_W'(1);
            if (bit_idx == len_r - LEN_W'(1)) begin
              bit_idx <= '0;
              rep_idx <= rep_idx + REP_W'(1);
              if ((rep_idx != rep_r - REP_W'(1)) && (gap_r != '0)) begin
                gap_cnt <= '0;
                state   <= GAP;
              end
            end else begin
              bit_idx <= bit_idx + LEN_W'(1);
            end
          end
        end
        GAP: begin
          valid_o <= 1'b0;
          if (gap_cnt == gap_r - GAP_W'(1)) begin
            gap_cnt <= '0;
            state   <= SEND;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: a slot-list model (bits, gap cycles, done) predicts every cycle.
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pat_i;
  logic [4:0]  len_i;
  logic [3:0]  rep_i;
  logic [3:0]  gap_i;
  logic        hold_i;
  logic        d_o;
  logic        valid_o;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  sent_cnt;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad = 0;
  int busy_cycles;
  int xfer_cycles;
  int last_sent;
  logic got_bits[$];

  pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .pat_i(pat_i), .len_i(len_i),
    .rep_i(rep_i), .gap_i(gap_i), .hold_i(hold_i), .d_o(d_o), .valid_o(valid_o),
    .busy(busy), .done(done), .err(err), .sent_cnt(sent_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream as slots: 0/1 = bit (stalls under hold), 2 = gap cycle, 3 = done.
  // hold_mode: 0 none, 1 random, 2 three cycles after the second bit.
  task automatic run_transfer(input logic [15:0] pat, input int len, input int rep,
                              input int gap, input int hold_mode, input bit b2b);
    int slots[$];
    int exp_sent;
    int cycles;
    int hold_run;
    int k;
    logic h;
    for (int r = 0; r < rep; r++) begin
      for (int b = len - 1; b >= 0; b--) slots.push_back(int'(pat[b]));
      if (r < rep - 1) for (int g = 0; g < gap; g++) slots.push_back(2);
    end
    slots.push_back(3);
    pat_i = pat; len_i = 5'(len); rep_i = 4'(rep); gap_i = 4'(gap);
    hold_i = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL accept: busy=%b valid_o=%b want busy=1 valid_o=0", busy, valid_o);
    end
    busy_cycles = 1; exp_sent = 0; cycles = 0; hold_run = 0;
    got_bits.delete();
    while (slots.size() > 0 && cycles < 1000) begin
      case (hold_mode)
        1: h = ($urandom_range(0, 3) == 0);
        2: h = (exp_sent == 2 && hold_run < 3);
        default: h = 1'b0;
      endcase
      if (hold_mode == 2 && h) hold_run++;
      hold_i = h;
      // junk on the argument inputs while busy must not disturb the transfer
      start = 1'($urandom_range(0, 1));
      pat_i = 16'($urandom); len_i = 5'($urandom); rep_i = 4'($urandom); gap_i = 4'($urandom);
      if (slots[0] == 3 && b2b) start = 1'b1;
      tick();
      cycles++;
      k = slots[0];
      total++;
      if (k == 3) begin
        if (done !== 1'b1 || valid_o !== 1'b0 || busy !== 1'b0 || sent_cnt !== 9'(exp_sent)) begin
          bad++;
          $display("FAIL done_cycle: done=%b valid_o=%b busy=%b sent_cnt=%0d want 1 0 0 %0d",
                   done, valid_o, busy, sent_cnt, exp_sent);
        end
        void'(slots.pop_front());
      end else begin
        if (done !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
          bad++;
          $display("FAIL busy_flags: done=%b busy=%b err=%b want 0 1 0 (cycle %0d)",
                   done, busy, err, cycles);
        end
        busy_cycles++;
        total++;
        if (k == 2 || h) begin
          if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_slot: valid_o=%b want 0 (cycle %0d)", valid_o, cycles);
          end
          if (k == 2) void'(slots.pop_front());
        end else begin
          exp_sent++;
          if (valid_o !== 1'b1 || d_o !== k[0]) begin
            bad++;
            $display("FAIL bit: valid_o=%b d_o=%b want 1 %0d (cycle %0d)", valid_o, d_o, k, cycles);
          end
          got_bits.push_back(d_o);
          void'(slots.pop_front());
        end
        total++;
        if (sent_cnt !== 9'(exp_sent)) begin
          bad++;
          $display("FAIL sent_cnt: got %0d want %0d", sent_cnt, exp_sent);
        end
      end
    end
    if (slots.size() > 0) begin
      total++; bad++;
      $display("FAIL timeout: %0d slots left", slots.size());
    end
    hold_i = 1'b0;
    xfer_cycles = cycles;
    last_sent = exp_sent;
    if (!b2b) begin
      start = 1'b0;
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || valid_o !== 1'b0 || sent_cnt !== 9'(exp_sent)) begin
        bad++;
        $display("FAIL after_done: done=%b busy=%b valid_o=%b sent_cnt=%0d want 0 0 0 %0d",
                 done, busy, valid_o, sent_cnt, exp_sent);
      end
    end
  endtask

  task automatic check_bits(input string name, input logic [15:0] exp, input int n);
    logic [15:0] got;
    got = '0;
    foreach (got_bits[i]) got = {got[14:0], got_bits[i]};
    total++;
    if (got_bits.size() != n || got !== exp) begin
      bad++;
      $display("FAIL %s: bits=%h count=%0d want %h count=%0d", name, got, got_bits.size(), exp, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hold_i = 1'b0;
    pat_i = '0; len_i = '0; rep_i = '0; gap_i = '0;
    tick(); tick();
    total++;
    if ({d_o, valid_o, busy, done, err} !== 5'b0 || sent_cnt !== 9'd0) begin
      bad++;
      $display("FAIL reset: d/v/busy/done/err=%b sent_cnt=%0d want 00000 0",
               {d_o, valid_o, busy, done, err}, sent_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_transfer(16'h0016, 5, 1, 0, 0, 1'b0);
    check_bits("basic_bits", 16'b10110, 5);
    total++;
    if (xfer_cycles != 6) begin
      bad++;
      $display("FAIL basic_latency: done after %0d edges want 6", xfer_cycles);
    end
  endtask

  task automatic test_rep_detect();
    int hits;
    logic [4:0] win;
    run_transfer(16'h0016, 5, 2, 0, 0, 1'b0);
    check_bits("rep_bits", 16'b1011010110, 10);
    hits = 0; win = '0;
    foreach (got_bits[i]) begin
      win = {win[3:0], got_bits[i]};
      if (i >= 4 && win == 5'b10110) hits++;
    end
    total++;
    if (hits != 2 || sent_cnt !== 9'd10) begin
      bad++;
      $display("FAIL rep_detect: hits=%0d sent_cnt=%0d want 2 10", hits, sent_cnt);
    end
  endtask

  task automatic test_gap();
    run_transfer(16'h0016, 5, 3, 2, 0, 1'b0);
    total++;
    if (busy_cycles != 20) begin
      bad++;
      $display("FAIL gap_busy: busy for %0d cycles want 20", busy_cycles);
    end
  endtask

  task automatic test_hold();
    run_transfer(16'h0016, 5, 1, 0, 2, 1'b0);
    check_bits("hold_bits", 16'b10110, 5);
    total++;
    if (xfer_cycles != 9) begin
      bad++;
      $display("FAIL hold_latency: done after %0d edges want 9", xfer_cycles);
    end
  endtask

  task automatic test_illegal();
    logic [4:0] lens [3] = '{5'd0, 5'd17, 5'd5};
    logic [3:0] reps [3] = '{4'd1, 4'd1, 4'd0};
    for (int i = 0; i < 3; i++) begin
      pat_i = 16'($urandom); len_i = lens[i]; rep_i = reps[i]; gap_i = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (err !== 1'b1 || valid_o !== 1'b0 || busy !== 1'b0 || sent_cnt !== 9'(last_sent)) begin
        bad++;
        $display("FAIL illegal_%0d: err=%b valid_o=%b busy=%b sent_cnt=%0d want 1 0 0 %0d",
                 i, err, valid_o, busy, sent_cnt, last_sent);
      end
      tick();
      total++;
      if (err !== 1'b0 || busy !== 1'b0 || valid_o !== 1'b0) begin
        bad++;
        $display("FAIL illegal_pulse_%0d: err=%b busy=%b valid_o=%b want 0 0 0", i, err, busy, valid_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    p = 16'hB5C3;
    pat_i = p; len_i = 5'd16; rep_i = 4'd2; gap_i = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (valid_o !== 1'b1 || d_o !== p[15 - i]) begin
        bad++;
        $display("FAIL mid_bit_%0d: valid_o=%b d_o=%b want 1 %b", i, valid_o, d_o, p[15 - i]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({d_o, valid_o, busy, done, err} !== 5'b0 || sent_cnt !== 9'd0) begin
      bad++;
      $display("FAIL mid_reset: d/v/busy/done/err=%b sent_cnt=%0d want 00000 0",
               {d_o, valid_o, busy, done, err}, sent_cnt);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_done: done=%b busy=%b valid_o=%b want 0 0 0", done, busy, valid_o);
    end
    run_transfer(16'h9E27, 16, 1, 0, 0, 1'b0);
    check_bits("mid_restart", 16'h9E27, 16);
  endtask

  task automatic test_back_to_back();
    run_transfer(16'h0005, 3, 2, 1, 0, 1'b1);
    run_transfer(16'h00A3, 8, 1, 0, 0, 1'b0);
    check_bits("b2b_second", 16'h00A3, 8);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_transfer(16'($urandom), $urandom_range(1, 16), $urandom_range(1, 4),
                   $urandom_range(0, 3), 1, (i < 24) && ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rep_detect();
    test_gap();
    test_hold();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
